demux4_regbank: RTL and testbench
=================================

// Module: demux4_regbank
// PURPOSE
//   Write-side counterpart of the 4-way 13-bit operand mux. Takes one WIDTH-bit
//   write bus plus a 2-bit select and routes it into one of four holding
//   registers (pointer/PC/stack-top class values). Each write is a
//   read-modify-write: LOAD, +1 or -1.
//   The four register outputs feed the operand mux; zero flags feed the loop
//   ([ / ]) decision logic.
// PARAMETERS
//   WIDTH      13   width of data bus and each holding register
//   RESET_VAL  0    value loaded into all four registers on reset
// PORTS
//   clk        in   1      system clock, all state on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   wr_valid   in   1      request present on sel/op/din
//   wr_ready   out  1      block can accept a request this cycle
//   sel        in   2      target register index 0..3
//   op         in   2      00 NOP, 01 LOAD din, 10 INC (+1), 11 DEC (-1)
//   din        in   WIDTH  LOAD data; ignored for NOP/INC/DEC
//   q_0..q_3   out  WIDTH  holding register contents (registered)
//   zero       out  4      zero[i] = (q_i == 0), combinational from q_i
//   done       out  1      one-cycle pulse: request retired, q updated
// BEHAVIOUR
//   Reset (async, rst_n=0): q_0..q_3=RESET_VAL, state=IDLE, wr_ready=1,
//     done=0, captured sel/op/din cleared. An in-flight request is dropped and
//     never produces done. Release takes effect on the next rising edge.
//   FSM, 2 states:
//     IDLE: wr_ready=1. wr_valid=1 at edge N captures sel, op and din, then
//       goes to EXEC. Otherwise stays in IDLE.
//     EXEC: wr_ready=0. At edge N+1 the result is written to q[sel_c],
//       done=1 for the cycle after N+1, and the FSM returns to IDLE.
//   Throughput: one request per 2 cycles. New data is visible on q and zero
//     in the same cycle done is high.
//   wr_valid while wr_ready=0 is ignored, not queued. The requester must hold
//     its request until it sees wr_ready=1 at a clock edge.
//   Arithmetic is modulo 2^WIDTH:
//     INC of 2^WIDTH-1 -> 0.
//     DEC of 0 -> 2^WIDTH-1.
//     No carry or borrow output.
//   NOP still takes the EXEC cycle and pulses done; no register changes.
//   Only q[sel_c] is written; the other three registers hold their values.
//   sel/op/din are sampled only at the accepting edge. Changes during EXEC
//     have no effect.
//   done is never high in two consecutive cycles.
// TESTING
//   1 Reset with RESET_VAL=0 -> q_0..3=0, zero=4'b1111, wr_ready=1, done=0.
//   2 LOAD sel=2 din=13'h1ABC at edge N -> wr_ready=0 in EXEC; q_2=1ABC and
//     zero[2]=0 with done=1 after edge N+1; q_0, q_1, q_3 unchanged.
//   3 LOAD sel=1 din=1FFF, then INC sel=1 -> q_1=0, zero[1]=1.
//     Then DEC sel=1 -> q_1=1FFF.
//   4 Hold wr_valid=1 continuously with INC sel=0 for 8 cycles -> 4 done
//     pulses, q_0=4, never two accepts on back-to-back edges.
//   5 Accept DEC sel=3 from q_3=5, assert rst_n=0 mid-EXEC -> q_3=RESET_VAL,
//     no done pulse, wr_ready=1 immediately.
//   6 NOP sel=0 with din=0x0AAA -> done pulse, all q unchanged, din ignored.

Source files
------------

// File: rtl/demux4_regbank_if.sv
// -----------------------------------------------------------------------------
// demux4_regbank_if
//   Write-request interface of the 4-way holding-register bank.
//   A requester (master) presents sel/op/din with wr_valid. The bank (slave)
//   answers with wr_ready and a one-cycle done pulse when the request retires.
//   Signals:
//     wr_valid  master->slave  request present on sel/op/din
//     wr_ready  slave->master  bank can accept a request this cycle
//     sel       master->slave  target register index 0..3
//     op        master->slave  00 NOP, 01 LOAD, 10 INC, 11 DEC
//     din       master->slave  LOAD data (WIDTH bits)
//     done      slave->master  request retired, q updated this cycle
// -----------------------------------------------------------------------------
interface demux4_regbank_if #(
  parameter int WIDTH = 13
);
  logic             wr_valid;
  logic             wr_ready;
  logic [1:0]       sel;
  logic [1:0]       op;
  logic [WIDTH-1:0] din;
  logic             done;

  modport master (
    output wr_valid, sel, op, din,
    input  wr_ready, done
  );

  modport slave (
    input  wr_valid, sel, op, din,
    output wr_ready, done
  );
endinterface

// File: rtl/demux4_regbank.sv
// -----------------------------------------------------------------------------
// demux4_regbank
//   Write-side counterpart of the 4-way operand mux. One request (sel, op, din)
//   is accepted in IDLE, then applied as a read-modify-write (NOP, LOAD, +1,
//   -1, modulo 2^WIDTH) to one of four holding registers in the EXEC cycle.
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        request interface (slave side): wr_valid/wr_ready, sel, op,
//                din, done
//     q_0..q_3   registered holding register contents
//     zero       zero[i] = (q_i == 0)
// -----------------------------------------------------------------------------
module demux4_regbank #(
  parameter int               WIDTH     = 13,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux4_regbank_if.slave      bus,
  output logic [WIDTH-1:0]     q_0,
  output logic [WIDTH-1:0]     q_1,
  output logic [WIDTH-1:0]     q_2,
  output logic [WIDTH-1:0]     q_3,
  output logic [3:0]           zero
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] reg_q [4];
  logic [WIDTH-1:0] reg_d [4];
  logic [WIDTH-1:0] result;

  // State register plus captured request, holding registers and done flop.
  // Reset drops any in-flight request so it can never produce done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      op_q    <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) reg_q[i] <= RESET_VAL;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      din_q   <= din_d;
      done_q  <= done_d;
      for (int i = 0; i < 4; i++) reg_q[i] <= reg_d[i];
    end
  end

  // Result of the captured operation on the selected register; the +1/-1
  // wrap naturally at WIDTH bits.
  always_comb begin
    result = reg_q[sel_q];
    case (op_q)
      OP_NOP:  result = reg_q[sel_q];
      OP_LOAD: result = din_q;
      OP_INC:  result = reg_q[sel_q] + WIDTH'(1);
      OP_DEC:  result = reg_q[sel_q] - WIDTH'(1);
      default: result = reg_q[sel_q];
    endcase
  end

  // Next-state logic. sel/op/din are captured only on the accepting edge,
  // so bus changes during EXEC are ignored; the write happens on leaving EXEC
  // and done is registered so it lines up with the new q value.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    op_d    = op_q;
    din_d   = din_q;
    done_d  = 1'b0;
    for (int i = 0; i < 4; i++) reg_d[i] = reg_q[i];
    case (state_q)
      IDLE: begin
        if (bus.wr_valid) begin
          sel_d   = bus.sel;
          op_d    = bus.op;
          din_d   = bus.din;
          state_d = EXEC;
        end
      end
      EXEC: begin
        reg_d[sel_q] = result;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ready only in IDLE, so a request held during EXEC is not
  // accepted until the cycle after the write.
  always_comb begin
    bus.wr_ready = (state_q == IDLE);
    bus.done     = done_q;
  end

  assign q_0  = reg_q[0];
  assign q_1  = reg_q[1];
  assign q_2  = reg_q[2];
  assign q_3  = reg_q[3];
  assign zero = {(reg_q[3] == '0), (reg_q[2] == '0),
                 (reg_q[1] == '0), (reg_q[0] == '0)};

endmodule

// File: tb/tb_demux4_regbank.sv
// -----------------------------------------------------------------------------
// tb_demux4_regbank
//   Directed self-checking bench for demux4_regbank with WIDTH=13 and
//   RESET_VAL=0. Inputs change and outputs are sampled 1 time unit after the
//   rising clock edge.
// -----------------------------------------------------------------------------
module tb_demux4_regbank;

  localparam int WIDTH = 13;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] q_0, q_1, q_2, q_3;
  logic [3:0]       zero;

  int check_count = 0;
  int error_count = 0;

  demux4_regbank_if #(.WIDTH(WIDTH)) bus ();

  demux4_regbank #(
    .WIDTH     (WIDTH),
    .RESET_VAL (13'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .q_0   (q_0),
    .q_1   (q_1),
    .q_2   (q_2),
    .q_3   (q_3),
    .zero  (zero)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one complete request: waits (bounded) for ready, presents it for the
  // accepting edge, scrambles the bus during EXEC, and stops in the cycle
  // where done is high so the caller can inspect q.
  task automatic applyStimulus(input string tag, input logic [1:0] sel,
                               input logic [1:0] op, input logic [WIDTH-1:0] din);
    int waited = 0;
    while (!bus.wr_ready && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_ready"}, 32'(bus.wr_ready), 32'd1);
    bus.wr_valid = 1'b1;
    bus.sel      = sel;
    bus.op       = op;
    bus.din      = din;
    tick();
    checkOutput({tag, "_busy"}, 32'(bus.wr_ready), 32'd0);
    checkOutput({tag, "_nodone"}, 32'(bus.done), 32'd0);
    bus.wr_valid = 1'b0;
    bus.sel      = ~sel;
    bus.op       = 2'b01;
    bus.din      = 13'h0F0F;
    tick();
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd1);
  endtask

  initial begin
    int done_pulses;
    int accepts;
    int back_to_back;
    int done_consec;
    logic prev_ready;
    logic prev_accept;
    logic prev_done;

    bus.wr_valid = 1'b0;
    bus.sel      = 2'd0;
    bus.op       = 2'd0;
    bus.din      = '0;
    rst_n        = 1'b0;

    // 1: reset state
    tick();
    tick();
    checkOutput("rst_q0", 32'(q_0), 32'h0);
    checkOutput("rst_q1", 32'(q_1), 32'h0);
    checkOutput("rst_q2", 32'(q_2), 32'h0);
    checkOutput("rst_q3", 32'(q_3), 32'h0);
    checkOutput("rst_zero", 32'(zero), 32'hF);
    checkOutput("rst_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();

    // 2: LOAD sel=2 din=1ABC
    applyStimulus("load2", 2'd2, 2'b01, 13'h1ABC);
    checkOutput("load2_q2", 32'(q_2), 32'h1ABC);
    checkOutput("load2_zero", 32'(zero), 32'hB);
    checkOutput("load2_q0", 32'(q_0), 32'h0);
    checkOutput("load2_q1", 32'(q_1), 32'h0);
    checkOutput("load2_q3", 32'(q_3), 32'h0);
    tick();
    checkOutput("load2_done_low", 32'(bus.done), 32'd0);

    // 3: LOAD 1FFF, INC wraps to 0, DEC wraps back to 1FFF
    applyStimulus("load1", 2'd1, 2'b01, 13'h1FFF);
    checkOutput("load1_q1", 32'(q_1), 32'h1FFF);
    applyStimulus("inc1", 2'd1, 2'b10, 13'h0123);
    checkOutput("inc1_q1", 32'(q_1), 32'h0);
    checkOutput("inc1_zero", 32'(zero), 32'hB);
    applyStimulus("dec1", 2'd1, 2'b11, 13'h0000);
    checkOutput("dec1_q1", 32'(q_1), 32'h1FFF);
    checkOutput("dec1_zero", 32'(zero), 32'h9);
    checkOutput("dec1_q2", 32'(q_2), 32'h1ABC);
    tick();

    // 4: wr_valid held for 8 edges with INC sel=0
    done_pulses  = 0;
    accepts      = 0;
    back_to_back = 0;
    done_consec  = 0;
    prev_accept  = 1'b0;
    prev_done    = bus.done;
    bus.wr_valid = 1'b1;
    bus.sel      = 2'd0;
    bus.op       = 2'b10;
    bus.din      = 13'h1555;
    for (int i = 0; i < 8; i++) begin
      prev_ready = bus.wr_ready;
      tick();
      if (prev_ready) begin
        accepts++;
        if (prev_accept) back_to_back++;
      end
      prev_accept = prev_ready;
      if (bus.done) begin
        done_pulses++;
        if (prev_done) done_consec++;
      end
      prev_done = bus.done;
    end
    bus.wr_valid = 1'b0;
    checkOutput("hold_done_pulses", 32'(done_pulses), 32'd4);
    checkOutput("hold_accepts", 32'(accepts), 32'd4);
    checkOutput("hold_back_to_back", 32'(back_to_back), 32'd0);
    checkOutput("hold_done_consec", 32'(done_consec), 32'd0);
    checkOutput("hold_q0", 32'(q_0), 32'h4);
    checkOutput("hold_q1", 32'(q_1), 32'h1FFF);
    tick();

    // 5: reset during EXEC drops the request
    applyStimulus("load3", 2'd3, 2'b01, 13'h0005);
    checkOutput("load3_q3", 32'(q_3), 32'h5);
    tick();
    bus.wr_valid = 1'b1;
    bus.sel      = 2'd3;
    bus.op       = 2'b11;
    bus.din      = '0;
    tick();
    checkOutput("rstx_busy", 32'(bus.wr_ready), 32'd0);
    bus.wr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstx_q3", 32'(q_3), 32'h0);
    checkOutput("rstx_q0", 32'(q_0), 32'h0);
    checkOutput("rstx_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("rstx_done", 32'(bus.done), 32'd0);
    tick();
    checkOutput("rstx_done_held", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("rstx_done_after", 32'(bus.done), 32'd0);
    checkOutput("rstx_q3_after", 32'(q_3), 32'h0);
    checkOutput("rstx_zero", 32'(zero), 32'hF);

    // 6: NOP ignores din but still pulses done
    applyStimulus("load1b", 2'd1, 2'b01, 13'h0123);
    checkOutput("load1b_q1", 32'(q_1), 32'h0123);
    applyStimulus("nop0", 2'd0, 2'b00, 13'h0AAA);
    checkOutput("nop0_q0", 32'(q_0), 32'h0);
    checkOutput("nop0_q1", 32'(q_1), 32'h0123);
    checkOutput("nop0_q2", 32'(q_2), 32'h0);
    checkOutput("nop0_q3", 32'(q_3), 32'h0);
    checkOutput("nop0_zero", 32'(zero), 32'hD);
    tick();
    checkOutput("nop0_done_low", 32'(bus.done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
